// File: rtl/cnn_layer_sequencer.sv
// Frame-level stage sequencer for the LeNet pipeline: releases C1..Tanh3 stage resets
// one at a time, advancing on a stage's done flag or when its cycle budget runs out.
module cnn_layer_sequencer #(
    parameter int          CNT_WIDTH    = 17,
    parameter int          C1_CYCLES    = 10199,
    parameter int          TANH1_CYCLES = 28224,
    parameter int          AP1_CYCLES   = 8,
    parameter int          C2_CYCLES    = 60192,
    parameter int          TANH2_CYCLES = 9600,
    parameter int          AP2_CYCLES   = 20,
    parameter int          C3_CYCLES    = 30,
    parameter int          TANH3_CYCLES = 1024,
    parameter logic [7:0]  DONE_MASK    = 8'b1001_0010
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_stage_done,
    output logic [7:0] o_stage_rst,
    output logic [3:0] o_stage_idx,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [7:0] o_timeout_flags
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

    // A zero budget still gives the stage one active cycle.
    localparam int B0 = (C1_CYCLES    == 0) ? 1 : C1_CYCLES;
    localparam int B1 = (TANH1_CYCLES == 0) ? 1 : TANH1_CYCLES;
    localparam int B2 = (AP1_CYCLES   == 0) ? 1 : AP1_CYCLES;
    localparam int B3 = (C2_CYCLES    == 0) ? 1 : C2_CYCLES;
    localparam int B4 = (TANH2_CYCLES == 0) ? 1 : TANH2_CYCLES;
    localparam int B5 = (AP2_CYCLES   == 0) ? 1 : AP2_CYCLES;
    localparam int B6 = (C3_CYCLES    == 0) ? 1 : C3_CYCLES;
    localparam int B7 = (TANH3_CYCLES == 0) ? 1 : TANH3_CYCLES;
    localparam int BW = CNT_WIDTH + 1;
    localparam longint CNT_SPAN = longint'(1) << CNT_WIDTH;

    if (B0 > CNT_SPAN || B1 > CNT_SPAN || B2 > CNT_SPAN || B3 > CNT_SPAN ||
        B4 > CNT_SPAN || B5 > CNT_SPAN || B6 > CNT_SPAN || B7 > CNT_SPAN) begin : g_budget_chk
        $error("cnn_layer_sequencer: a stage budget exceeds 2**CNT_WIDTH");
    end

    state_t               r_state, w_state;
    logic [2:0]           r_k, w_k;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
    logic [7:0]           r_stage_rst, w_stage_rst;
    logic [3:0]           r_stage_idx, w_stage_idx;
    logic                 r_busy, w_busy;
    logic                 r_frame_done, w_frame_done;
    logic [7:0]           r_tflags, w_tflags;

    logic [BW-1:0]        w_budget;
    logic                 w_expire;
    logic                 w_done;
    logic [2:0]           w_k_inc;

    always_comb begin
        w_budget = BW'(B0);
        case (r_k)
            3'd0: w_budget = BW'(B0);
            3'd1: w_budget = BW'(B1);
            3'd2: w_budget = BW'(B2);
            3'd3: w_budget = BW'(B3);
            3'd4: w_budget = BW'(B4);
            3'd5: w_budget = BW'(B5);
            3'd6: w_budget = BW'(B6);
            default: w_budget = BW'(B7);
        endcase
    end

    assign w_expire = ({1'b0, r_cnt} == (w_budget - 1'b1));
    assign w_done   = DONE_MASK[r_k] & i_stage_done[r_k];
    assign w_k_inc  = r_k + 3'd1;

    always_comb begin
        w_state      = r_state;
        w_k          = r_k;
        w_cnt        = r_cnt;
        w_stage_rst  = r_stage_rst;
        w_stage_idx  = r_stage_idx;
        w_busy       = r_busy;
        w_frame_done = 1'b0;
        w_tflags     = r_tflags;
        case (r_state)
            S_IDLE: begin
                // A start coinciding with frame_done waits for the next IDLE cycle.
                if (i_start && !r_frame_done) begin
                    w_state     = S_FLUSH;
                    w_stage_rst = 8'hFF;
                    w_stage_idx = 4'd8;
                    w_busy      = 1'b1;
                    w_tflags    = 8'h00;
                    w_cnt       = '0;
                end
            end
            S_FLUSH: begin
                if (i_abort) begin
                    w_state     = S_IDLE;
                    w_stage_rst = 8'hFF;
                    w_stage_idx = 4'd8;
                    w_busy      = 1'b0;
                end else begin
                    w_state        = S_RUN;
                    w_k            = 3'd0;
                    w_cnt          = '0;
                    w_stage_rst[0] = 1'b0;
                    w_stage_idx    = 4'd0;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state     = S_IDLE;
                    w_stage_rst = 8'hFF;
                    w_stage_idx = 4'd8;
                    w_busy      = 1'b0;
                end else if (w_done || w_expire) begin
                    if (!w_done && DONE_MASK[r_k])
                        w_tflags[r_k] = 1'b1;
                    if (r_k != 3'd7) begin
                        w_k                  = w_k_inc;
                        w_cnt                = '0;
                        w_stage_rst[w_k_inc] = 1'b0;
                        w_stage_idx          = {1'b0, w_k_inc};
                    end else begin
                        // Stage resets stay released so results remain readable.
                        w_state      = S_IDLE;
                        w_frame_done = 1'b1;
                        w_busy       = 1'b0;
                        w_stage_idx  = 4'd8;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state     = S_IDLE;
                w_stage_rst = 8'hFF;
                w_stage_idx = 4'd8;
                w_busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_k          <= 3'd0;
            r_cnt        <= '0;
            r_stage_rst  <= 8'hFF;
            r_stage_idx  <= 4'd8;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_tflags     <= 8'h00;
        end else begin
            r_state      <= w_state;
            r_k          <= w_k;
            r_cnt        <= w_cnt;
            r_stage_rst  <= w_stage_rst;
            r_stage_idx  <= w_stage_idx;
            r_busy       <= w_busy;
            r_frame_done <= w_frame_done;
            r_tflags     <= w_tflags;
        end
    end

    assign o_stage_rst     = r_stage_rst;
    assign o_stage_idx     = r_stage_idx;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;
    assign o_timeout_flags = r_tflags;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with every stage budget set to 4 cycles.
module tb_cnn_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] stage_done;
    logic [7:0] stage_rst;
    logic [3:0] stage_idx;
    logic       busy;
    logic       frame_done;
    logic [7:0] timeout_flags;

    int checks   = 0;
    int failures = 0;
    int rel [8];
    int dcyc [8];

    cnn_layer_sequencer #(
        .CNT_WIDTH(17), .C1_CYCLES(4), .TANH1_CYCLES(4), .AP1_CYCLES(4), .C2_CYCLES(4),
        .TANH2_CYCLES(4), .AP2_CYCLES(4), .C3_CYCLES(4), .TANH3_CYCLES(4),
        .DONE_MASK(8'b1001_0010)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_stage_done(stage_done), .o_stage_rst(stage_rst), .o_stage_idx(stage_idx),
        .o_busy(busy), .o_frame_done(frame_done), .o_timeout_flags(timeout_flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rst"},   32'(stage_rst), 32'hFF);
        chk({tag, " idx"},   32'(stage_idx), 32'd8);
        chk({tag, " busy"},  32'(busy), 32'd0);
        chk({tag, " fdone"}, 32'(frame_done), 32'd0);
        chk({tag, " flags"}, 32'(timeout_flags), 32'h00);
    endtask

    // Start pulse sampled at cycle 0; stage k released at rel[k]; frame_done at cycle fd.
    task automatic run_frame(input string name, input int fd, input logic [7:0] flags,
                             input logic hold0, input int start_at);
        logic [7:0] exp_rst;
        int         exp_idx;
        stage_done = {7'b0, hold0};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= fd + 1; c++) begin
            exp_rst = 8'h00;
            exp_idx = 8;
            for (int k = 0; k < 8; k++) begin
                exp_rst[k] = (c < rel[k]);
                if (c >= rel[k] && c < fd) exp_idx = k;
            end
            chk($sformatf("%s c%0d stage_rst", name, c), 32'(stage_rst), 32'(exp_rst));
            chk($sformatf("%s c%0d stage_idx", name, c), 32'(stage_idx), 32'(exp_idx));
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c < fd));
            chk($sformatf("%s c%0d frame_done", name, c), 32'(frame_done), 32'(c == fd));
            if (c == 1)
                chk($sformatf("%s flags cleared", name), 32'(timeout_flags), 32'h00);
            if (c == fd)
                chk($sformatf("%s flags", name), 32'(timeout_flags), 32'(flags));
            stage_done = {7'b0, hold0};
            for (int k = 0; k < 8; k++)
                if (dcyc[k] == c) stage_done[k] = 1'b1;
            start = (c == start_at);
            step();
        end
        start      = 1'b0;
        stage_done = 8'h00;
    endtask

    task automatic set_nominal();
        rel  = '{2, 6, 10, 14, 18, 22, 26, 30};
        dcyc = '{-1, -1, -1, -1, -1, -1, -1, -1};
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        stage_done = 8'h00;
        step();
        step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();
        chk_reset_vals("idle");

        set_nominal();
        run_frame("nominal", 34, 8'b1001_0010, 1'b0, -1);
        step();

        rel  = '{2, 6, 7, 11, 15, 19, 23, 27};
        dcyc = '{-1, 6, -1, -1, -1, -1, -1, -1};
        run_frame("early", 31, 8'b1001_0000, 1'b0, -1);
        step();

        // done and expiry coincide on stage 4; a start on the frame_done cycle is dropped
        set_nominal();
        dcyc[4] = 21;
        run_frame("simul", 34, 8'b1000_0010, 1'b0, 34);
        step();

        set_nominal();
        run_frame("ignored", 34, 8'b1001_0010, 1'b1, 10);
        step();

        // abort during stage 3 at cnt=2 (cycle 16)
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 16; c++) step();
        chk("abort pre idx", 32'(stage_idx), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort rst",   32'(stage_rst), 32'hFF);
        chk("abort busy",  32'(busy), 32'd0);
        chk("abort idx",   32'(stage_idx), 32'd8);
        chk("abort flags", 32'(timeout_flags), 32'b0000_0010);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("abort quiet fdone %0d", c), 32'(frame_done), 32'd0);
            chk($sformatf("abort quiet busy %0d", c), 32'(busy), 32'd0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort idle rst", 32'(stage_rst), 32'hFF);
        chk("abort idle busy", 32'(busy), 32'd0);
        set_nominal();
        run_frame("post_abort", 34, 8'b1001_0010, 1'b0, -1);
        step();

        // reset while stage 5 runs (released at cycle 22)
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 23; c++) step();
        chk("midreset pre idx", 32'(stage_idx), 32'd5);
        reset = 1'b1;
        step();
        chk_reset_vals("midreset");
        reset = 1'b0;
        step();
        set_nominal();
        run_frame("post_reset", 34, 8'b1001_0010, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
